// File: rtl/disp_scan_n.sv
// Multiplexed seven-segment driver: binary value -> BCD via sequential shift-add-3,
// scanned over DIGITS active-low cathodes with leading-zero blanking, blink and saturation.
module disp_scan_n #(
  parameter int DIGITS    = 2,
  parameter int VAL_W     = 7,
  parameter int SCAN_DIV  = 1,
  parameter int BLINK_DIV = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  input  logic             blank_lz,
  input  logic             blink,
  output logic [7:0]       seg_cat,
  output logic [3:0]       seg_data,
  output logic             busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int ITR_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_SHOWN = pow10(DIGITS) - 64'd1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state, state_next;
  logic [VAL_W-1:0]   shift_reg, buf_val, cap_val;
  logic [BCD_W-1:0]   bcd, adj, bcd_step, shown;
  logic [ITR_W-1:0]   iter;
  logic               sat, pending, last_iter, capture, cap_big;

  logic [IDX_W-1:0]   idx;
  logic [DIV_W-1:0]   div;
  logic [BLK_W-1:0]   blk_cnt;
  logic               phase, slot_end;
  logic [DIGITS-1:0]  lead_zero;
  logic               above_zero;
  logic [7:0]         cat_sel;
  logic [3:0]         digit_code;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A completing conversion restarts at once if a load is pending or arrives on that edge.
  always_comb begin
    last_iter  = (state == CONV) && (iter == ITR_W'(VAL_W - 1));
    capture    = ((state == IDLE) && load) || (last_iter && (load || pending));
    cap_val    = ((state == CONV) && !load) ? buf_val : value;
    cap_big    = ({{(64 - VAL_W){1'b0}}, cap_val} > MAX_SHOWN);
    state_next = state;
    case (state)
      IDLE: if (load) state_next = CONV;
      CONV: if (last_iter && !(load || pending)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_step = (adj << 1) | BCD_W'(shift_reg[VAL_W-1]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      buf_val   <= '0;
      bcd       <= '0;
      iter      <= '0;
      sat       <= 1'b0;
      pending   <= 1'b0;
      shown     <= '0;
    end else begin
      if (load) buf_val <= value;
      if (capture) begin
        shift_reg <= cap_val;
        bcd       <= '0;
        iter      <= '0;
        sat       <= cap_big;
      end else if (state == CONV) begin
        shift_reg <= shift_reg << 1;
        bcd       <= bcd_step;
        iter      <= iter + ITR_W'(1);
      end
      if (last_iter) begin
        shown   <= sat ? {DIGITS{4'd9}} : bcd_step;
        pending <= 1'b0;
      end else if ((state == CONV) && load) begin
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div <= '0;
      idx <= '0;
    end else begin
      div <= slot_end ? '0 : div + DIV_W'(1);
      if (slot_end) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !blink) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
    end else if (!en) begin
      blk_cnt <= '0;
    end else if (slot_end) begin
      if (blk_cnt == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero; digit 0 never is.
  always_comb begin
    slot_end   = (div == DIV_W'(SCAN_DIV - 1));
    lead_zero  = '0;
    above_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      above_zero   = above_zero && (shown[4*i +: 4] == 4'd0);
      lead_zero[i] = above_zero;
    end
    cat_sel    = 8'hFF;
    digit_code = 4'd15;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cat_sel[i] = 1'b0;
        digit_code = (blank_lz && lead_zero[i]) ? 4'd15 : shown[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en || (blink && phase)) begin
      seg_cat  <= 8'hFF;
      seg_data <= 4'd15;
    end else begin
      seg_cat  <= cat_sel;
      seg_data <= digit_code;
    end
  end

endmodule

// File: tb/tb_disp_scan_n.sv
// Scoreboard bench for disp_scan_n: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_disp_scan_n;

  localparam int DIGITS    = 2;
  localparam int VAL_W     = 7;
  localparam int SCAN_DIV  = 1;
  localparam int BLINK_DIV = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b1;
  logic [VAL_W-1:0] value = 7'd99;
  logic             load = 1'b1;
  logic             blank_lz = 1'b0;
  logic             blink = 1'b0;
  logic [7:0]       seg_cat;
  logic [3:0]       seg_data;
  logic             busy;

  disp_scan_n #(
    .DIGITS(DIGITS), .VAL_W(VAL_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .load(load),
    .blank_lz(blank_lz), .blink(blink), .seg_cat(seg_cat), .seg_data(seg_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    bit          is_busy;
    logic [7:0]  cat;
    logic [3:0]  data;
    logic        bsy;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic expect_seg(input int at, input logic [7:0] cat, input logic [3:0] data,
                            input string name);
    exp_t e;
    e.at = at; e.is_busy = 1'b0; e.cat = cat; e.data = data; e.bsy = 1'b0; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_busy(input int at, input logic b, input string name);
    exp_t e;
    e.at = at; e.is_busy = 1'b1; e.cat = 8'h00; e.data = 4'h0; e.bsy = b; e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    n_checks++;
    if (e.at < cyc)
      $display("[TB] FAIL %s: expectation for cycle %0d checked late at cycle %0d",
               e.name, e.at, cyc);
    else if (e.is_busy) begin
      if (busy === e.bsy) n_pass++;
      else $display("[TB] FAIL %s @%0d: busy got %b expected %b", e.name, cyc, busy, e.bsy);
    end else begin
      if (seg_cat === e.cat && seg_data === e.data) n_pass++;
      else $display("[TB] FAIL %s @%0d: cat/data got %h/%0d expected %h/%0d",
                    e.name, cyc, seg_cat, seg_data, e.cat, e.data);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      checkOutput(mon_e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [VAL_W-1:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  // Forces the scan back to digit 0 so the next four slots are FE,FD,FE,FD.
  task automatic restart_scan(input logic [3:0] d0, input logic [3:0] d1, input string name);
    en = 1'b0;
    tick();
    expect_seg(cyc, 8'hFF, 4'd15, {name, "_dark"});
    en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (k % 2 == 1) expect_seg(cyc + k, 8'hFE, d0, {name, "_d0"});
      else            expect_seg(cyc + k, 8'hFD, d1, {name, "_d1"});
    end
    repeat (4) tick();
  endtask

  task automatic conv_check(input logic [VAL_W-1:0] v, input logic [3:0] d0,
                            input logic [3:0] d1, input string name);
    int t;
    expect_busy(cyc, 1'b0, {name, "_idle"});
    applyStimulus(v);
    t = cyc;
    for (int k = 0; k < VAL_W; k++) expect_busy(t + k, 1'b1, {name, "_busy"});
    expect_busy(t + VAL_W, 1'b0, {name, "_done"});
    repeat (VAL_W) tick();
    restart_scan(d0, d1, name);
  endtask

  initial begin
    int t;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_seg(cyc, 8'hFF, 4'd15, "reset_seg");
      expect_busy(cyc, 1'b0, "reset_busy");
    end
    rst_n = 1'b1;
    load  = 1'b0;
    expect_seg(cyc + 1, 8'hFE, 4'd0, "post_reset_d0");
    expect_busy(cyc + 1, 1'b0, "post_reset_busy");
    expect_seg(cyc + 2, 8'hFD, 4'd0, "post_reset_d1");
    repeat (2) tick();

    conv_check(7'd23, 4'd3, 4'd2, "conv23");

    blank_lz = 1'b1;
    conv_check(7'd5, 4'd5, 4'd15, "blank5");
    blank_lz = 1'b0;
    restart_scan(4'd5, 4'd0, "noblank5");
    blank_lz = 1'b1;
    conv_check(7'd0, 4'd0, 4'd15, "blank0");
    conv_check(7'd99, 4'd9, 4'd9, "max99");
    conv_check(7'd100, 4'd9, 4'd9, "sat100");
    blank_lz = 1'b0;
    conv_check(7'd120, 4'd9, 4'd9, "sat120");

    // Load during conversion: busy stays high across both conversions.
    applyStimulus(7'd40);
    t = cyc;
    for (int k = 0; k < 2 * VAL_W; k++) expect_busy(t + k, 1'b1, "b2b_busy");
    expect_busy(t + 2 * VAL_W, 1'b0, "b2b_done");
    repeat (2) tick();
    applyStimulus(7'd17);
    repeat (2 * VAL_W - 3) tick();
    restart_scan(4'd7, 4'd1, "b2b17");

    // Load landing exactly on the completion edge.
    applyStimulus(7'd23);
    t = cyc;
    for (int k = 0; k < 2 * VAL_W; k++) expect_busy(t + k, 1'b1, "coll_busy");
    expect_busy(t + 2 * VAL_W, 1'b0, "coll_done");
    repeat (VAL_W - 1) tick();
    applyStimulus(7'd45);
    repeat (VAL_W) tick();
    restart_scan(4'd5, 4'd4, "coll45");

    blink = 1'b1;
    en    = 1'b0;
    tick();
    t = cyc;
    expect_seg(t, 8'hFF, 4'd15, "blink_off");
    en = 1'b1;
    expect_seg(t + 1, 8'hFE, 4'd5, "blink_on1");
    expect_seg(t + 2, 8'hFD, 4'd4, "blink_on2");
    expect_seg(t + 3, 8'hFE, 4'd5, "blink_on3");
    expect_seg(t + 4, 8'hFD, 4'd4, "blink_on4");
    for (int k = 5; k <= 8; k++) expect_seg(t + k, 8'hFF, 4'd15, "blink_dark");
    expect_seg(t + 9, 8'hFE, 4'd5, "blink_back1");
    expect_seg(t + 10, 8'hFD, 4'd4, "blink_back2");
    repeat (10) tick();
    en = 1'b0;
    expect_seg(t + 11, 8'hFF, 4'd15, "en_drop");
    tick();
    en = 1'b1;
    expect_seg(t + 12, 8'hFE, 4'd5, "en_rise_d0");
    expect_seg(t + 13, 8'hFD, 4'd4, "en_rise_d1");
    repeat (2) tick();
    blink = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/disp_scan_n.md
# disp_scan_n

Parametrised multiplexed seven-segment display driver for the countdown/defuse game. Accepts a binary value (countdown remaining, user-set defuse time), converts it to BCD with a sequential shift-add-3 engine, and time-multiplexes DIGITS active-low cathode lines. Adds three features: optional leading-zero blanking, a blink mode, and overflow saturation. The 4-bit digit code output feeds the team's existing segment decoder, where code 15 means blank.

## Interface
Parameters:
- DIGITS, 2, number of scanned digits, 1..8
- VAL_W, 7, width of binary input value, 1..27
- SCAN_DIV, 1, clocks per digit slot, ≥1
- BLINK_DIV, 64, scan slots per blink half-period, ≥1

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  display enable (game switch); 0 = dark
- value  in  VAL_W  binary value to display
- load  in  1  one-cycle strobe; capture value
- blank_lz  in  1  blank leading zeros when 1
- blink  in  1  flash whole display when 1
- seg_cat  out  8  active-low digit select; bit i = digit i (0 = units)
- seg_data  out  4  BCD code of selected digit; 15 = blank
- busy  out  1  conversion in progress

## Operation
- Reset (rst_n=0 at an edge):
  - seg_cat=8'hFF, seg_data=15, busy=0.
  - Shown-digit register is all 0.
  - Scan index, divider, blink counter and phase are 0.
  - The pending flag is cleared.
- Converter FSM has two states, IDLE and CONV.
  - IDLE + load: capture value into the shift register, clear the BCD accumulator, go to CONV.
  - CONV runs exactly VAL_W iterations, one per clock. Each iteration adds 3 to every BCD nibble ≥5, then shifts left one bit, bringing in the MSB of the value.
  - After the last iteration, write the shown-digit register and return to IDLE.
- Saturation: if the captured value > 10^DIGITS−1, every shown digit becomes 9. Detect this with a comparison at capture time; the conversion still runs its full length.
- Load while busy: set pending and overwrite the capture buffer with the new value (the last load wins).
  - On the completion edge with pending set, go straight back to CONV with the buffered value and clear pending.
  - busy stays high with no gap.
- Scan:
  - The divider counts 0..SCAN_DIV−1. On wrap, the scan index advances 0..DIGITS−1 and then wraps to 0.
  - seg_cat and seg_data are registered and update together.
  - seg_cat bit idx is low and all other bits are high. Bits ≥ DIGITS are always 1.
- Leading-zero blanking:
  - With blank_lz=1, each digit above the most significant nonzero digit outputs code 15.
  - Digit 0 is never blanked, so a value of 0 shows "0".
- Blink:
  - The blink counter counts completed scan slots. The phase toggles every BLINK_DIV slots.
  - With blink=1 and phase=1, seg_cat=8'hFF and seg_data=15 while scanning continues.
  - With blink=0, the phase is forced to 0.
- en=0:
  - From the next edge, seg_cat=8'hFF and seg_data=15. Scan index, divider and blink counter reset to 0.
  - The converter keeps running and the shown digits are retained.
  - When en rises, the first slot is digit 0.

## Timing
- load sampled at edge t:
  - busy=1 from t+1.
  - Shown digits update at edge t+VAL_W.
  - busy=0 from t+VAL_W, unless a reload is pending.
- seg_data reflects the new digits on the first slot boundary at or after the update edge. Latency to that boundary is at most SCAN_DIV cycles.
- load with rst_n=0: reset wins.
- Reset mid-conversion: the conversion is aborted and the shown digits return to 0.
- Simultaneous completion and new load: treated as a pending reload.
- Slot period is SCAN_DIV clocks. Frame period is DIGITS×SCAN_DIV clocks.

## Test plan
Defaults for all scenarios: DIGITS=2, VAL_W=7, SCAN_DIV=1, BLINK_DIV=4.
- Reset: hold rst_n=0 for 3 cycles → seg_cat=FF, seg_data=15, busy=0. After release with en=1, output alternates FE/0 and FD/0.
- Basic conversion: load value=23 → busy high for exactly 7 cycles. Then output alternates FE/3 and FD/2.
- Blanking: load value=5 with blank_lz=1 → FE/5 and FD/15. With blank_lz=0 → FD/0.
- Saturation: load value=120 → FE/9 and FD/9.
- Back-to-back loads: load 40, then load 17 three cycles later → busy high continuously for 14 cycles. Final display is FE/7 and FD/1.
- Enable and blink: with en=1 and blink=1 → 4 scanned slots, then 4 slots of FF/15, repeating. Drop en mid-frame → FF/15 at the next edge. Raise en → first slot is FE.
